dma_ctrl_sequencer: RTL and testbench

- Avalon-MM control-port master that programs a DMA controller core for one memory-to-memory transfer per start request.
- Sequence: clear status, write read address, write write address, write length, write control (GO); then poll status DONE, clear status, report completion.
- Generalised over address/length width, transfer size and read latency.
- Adds a poll timeout with soft-reset recovery and request validation.
- Sits between user/top-level control logic and the DMA core's control slave.

---
 rtl/dma_pkg.sv | 58 +++++
 rtl/avm_ctrl_master.sv | 52 +++++
 rtl/dma_ctrl_sequencer.sv | 132 +++++++++++++
 tb/tb_dma_ctrl_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA control-port sequencer: register map, control bits,
// FSM states, error codes and the one-cycle bus command passed to the bus master.
package dma_pkg;

   localparam logic [2:0] REG_STATUS = 3'd0;
   localparam logic [2:0] REG_RADDR  = 3'd1;
   localparam logic [2:0] REG_WADDR  = 3'd2;
   localparam logic [2:0] REG_LEN    = 3'd3;
   localparam logic [2:0] REG_CTRL   = 3'd6;

   localparam logic [31:0] CTRL_BYTE   = 32'h0000_0001;
   localparam logic [31:0] CTRL_HW     = 32'h0000_0002;
   localparam logic [31:0] CTRL_WORD   = 32'h0000_0004;
   localparam logic [31:0] CTRL_GO     = 32'h0000_0008;
   localparam logic [31:0] CTRL_LEEN   = 32'h0000_0080;
   localparam logic [31:0] CTRL_SWRST  = 32'h0000_1000;
   localparam logic [31:0] STATUS_DONE = 32'h0000_0001;

   typedef enum logic [3:0] {
      ST_IDLE, ST_REJECT, ST_CLR_STAT, ST_WR_RADDR, ST_WR_WADDR, ST_WR_LEN, ST_WR_CTRL,
      ST_POLL_RD, ST_POLL_WAIT, ST_SWRST1, ST_SWRST2, ST_CLR_DONE, ST_FINISH
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_ZERO_LEN = 2'b01,
      ERR_MISALIGN = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } err_code_t;

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [2:0]  addr;
      logic [31:0] data;
   } avm_cmd_t;

   // Size 11 is treated as a word transfer.
   function automatic logic [31:0] ctrl_word(input logic [1:0] size);
      logic [31:0] w;
      w = CTRL_GO | CTRL_LEEN;
      case (size)
         2'b00:   w = w | CTRL_BYTE;
         2'b01:   w = w | CTRL_HW;
         default: w = w | CTRL_WORD;
      endcase
      return w;
   endfunction

   function automatic err_code_t check_request(input logic len_zero, input logic [1:0] len_lsb,
                                               input logic [1:0] size);
      if (len_zero)                        return ERR_ZERO_LEN;
      if (size == 2'b01 && len_lsb[0])     return ERR_MISALIGN;
      if (size[1] && len_lsb != 2'b00)     return ERR_MISALIGN;
      return ERR_NONE;
   endfunction

endpackage

// File: rtl/avm_ctrl_master.sv
// Avalon-MM control-port master: registers a one-cycle read/write command onto the bus
// and flags the cycle in which read data is valid, READ_LATENCY cycles after the strobe.
module avm_ctrl_master import dma_pkg::*; #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  avm_cmd_t    cmd,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic [2:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata
);

   logic [2:0]              avm_address_reg;
   logic                    avm_chipselect_reg;
   logic                    avm_write_n_reg;
   logic [31:0]             avm_writedata_reg;
   logic [READ_LATENCY-1:0] rd_pipe_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         avm_address_reg    <= '0;
         avm_chipselect_reg <= 1'b0;
         avm_write_n_reg    <= 1'b1;
         avm_writedata_reg  <= '0;
         rd_pipe_reg        <= '0;
      end else begin
         avm_chipselect_reg <= cmd.wr | cmd.rd;
         avm_write_n_reg    <= ~cmd.wr;
         if (cmd.wr | cmd.rd) begin
            avm_address_reg   <= cmd.addr;
            avm_writedata_reg <= cmd.wr ? cmd.data : 32'h0;
         end
         // Tag the read strobe cycle and age it until the slave's data is due.
         rd_pipe_reg[0] <= avm_chipselect_reg & avm_write_n_reg;
         for (int i = 1; i < READ_LATENCY; i++)
            rd_pipe_reg[i] <= rd_pipe_reg[i-1];
      end
   end

   assign rd_valid       = rd_pipe_reg[READ_LATENCY-1];
   assign rd_data        = avm_readdata;
   assign avm_address    = avm_address_reg;
   assign avm_chipselect = avm_chipselect_reg;
   assign avm_write_n    = avm_write_n_reg;
   assign avm_writedata  = avm_writedata_reg;

endmodule

// File: rtl/dma_ctrl_sequencer.sv
// Programs a DMA core for one memory-to-memory transfer per start request, polls for
// completion with a timeout, and recovers from a stuck core by soft-resetting it.
module dma_ctrl_sequencer import dma_pkg::*; #(
   parameter int ADDR_W       = 32,
   parameter int LEN_W        = 11,
   parameter int READ_LATENCY = 1,
   parameter int TIMEOUT_CYC  = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [1:0]        size,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [2:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT_CYC);

   state_t            state_reg, state_next;
   err_code_t         err_code_reg, req_code;
   logic [ADDR_W-1:0] src_reg, dst_reg;
   logic [LEN_W-1:0]  len_reg;
   logic [1:0]        size_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              busy_reg, done_reg, err_reg;
   avm_cmd_t          cmd;
   logic              rd_valid, status_done, timed_out;
   logic [31:0]       rd_data;

   assign req_code    = check_request(length == '0, 2'(length), size);
   assign status_done = (rd_data & STATUS_DONE) != 32'h0;
   // Counts the current sample cycle too, so the limit is reached exactly at TIMEOUT_CYC.
   assign timed_out   = ({1'b0, cnt_reg} + 1'b1) >= TIMEOUT_LIM;

   always_comb begin
      state_next = state_reg;
      cmd        = '0;
      case (state_reg)
         ST_IDLE:      if (start) state_next = (req_code == ERR_NONE) ? ST_CLR_STAT : ST_REJECT;
         ST_REJECT:    state_next = ST_FINISH;
         ST_CLR_STAT:  state_next = ST_WR_RADDR;
         ST_WR_RADDR:  state_next = ST_WR_WADDR;
         ST_WR_WADDR:  state_next = ST_WR_LEN;
         ST_WR_LEN:    state_next = ST_WR_CTRL;
         ST_WR_CTRL:   state_next = ST_POLL_RD;
         ST_POLL_RD:   state_next = ST_POLL_WAIT;
         ST_POLL_WAIT: if (rd_valid) begin
            if (status_done)    state_next = ST_CLR_DONE;
            else if (timed_out) state_next = ST_SWRST1;
            else                state_next = ST_POLL_RD;
         end
         ST_SWRST1:    state_next = ST_SWRST2;
         ST_SWRST2:    state_next = ST_CLR_DONE;
         ST_CLR_DONE:  state_next = ST_FINISH;
         default:      state_next = ST_IDLE;
      endcase

      // Command is chosen for the state being entered so its strobe is visible during that state.
      case (state_next)
         ST_CLR_STAT, ST_CLR_DONE: begin cmd.wr = 1'b1; cmd.addr = REG_STATUS; end
         ST_WR_RADDR: begin cmd.wr = 1'b1; cmd.addr = REG_RADDR; cmd.data = 32'(src_reg); end
         ST_WR_WADDR: begin cmd.wr = 1'b1; cmd.addr = REG_WADDR; cmd.data = 32'(dst_reg); end
         ST_WR_LEN:   begin cmd.wr = 1'b1; cmd.addr = REG_LEN;   cmd.data = 32'(len_reg); end
         ST_WR_CTRL:  begin cmd.wr = 1'b1; cmd.addr = REG_CTRL;  cmd.data = ctrl_word(size_reg); end
         ST_SWRST1, ST_SWRST2: begin cmd.wr = 1'b1; cmd.addr = REG_CTRL; cmd.data = CTRL_SWRST; end
         ST_POLL_RD:  begin cmd.rd = 1'b1; cmd.addr = REG_STATUS; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         err_code_reg <= ERR_NONE;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         src_reg      <= '0;
         dst_reg      <= '0;
         len_reg      <= '0;
         size_reg     <= '0;
         cnt_reg      <= '0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next != ST_IDLE) && (state_next != ST_FINISH);
         done_reg  <= (state_next == ST_FINISH);
         err_reg   <= (state_next == ST_FINISH) && (err_code_reg != ERR_NONE);
         if (state_reg == ST_IDLE && start) begin
            src_reg      <= src_addr;
            dst_reg      <= dst_addr;
            len_reg      <= length;
            size_reg     <= size;
            err_code_reg <= req_code;
            cnt_reg      <= '0;
         end else if ((state_reg == ST_POLL_RD || state_reg == ST_POLL_WAIT) && cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (state_next == ST_SWRST1)
            err_code_reg <= ERR_TIMEOUT;
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign err      = err_reg;
   assign err_code = err_code_reg;

   avm_ctrl_master #(.READ_LATENCY(READ_LATENCY)) u_avm (
      .clk            (clk),
      .reset          (reset),
      .cmd            (cmd),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write_n    (avm_write_n),
      .avm_writedata  (avm_writedata),
      .avm_readdata   (avm_readdata)
   );

endmodule

// File: tb/tb_dma_ctrl_sequencer.sv
// Scoreboard bench: a transfer-level model queues expected bus transactions and completions;
// a monitor pops and compares them as the DUT drives the bus and pulses done.
module tb_dma_ctrl_sequencer;

   localparam int ADDR_W    = 20;
   localparam int LEN_W     = 11;
   localparam int RL        = 2;
   localparam int TMO       = 20;
   // Each poll occupies 1+RL cycles; the core is given up on once TMO cycles are used.
   localparam int MAX_POLLS = (TMO + RL) / (RL + 1);

   typedef struct packed {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] data;
   } bus_ev_t;

   typedef struct packed {
      logic       err;
      logic [1:0] code;
   } cpl_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] src_addr, dst_addr;
   logic [LEN_W-1:0]  length;
   logic [1:0]        size;
   logic              busy, done, err;
   logic [1:0]        err_code;
   logic [2:0]        avm_address;
   logic              avm_chipselect, avm_write_n;
   logic [31:0]       avm_writedata, avm_readdata;

   bus_ev_t exp_bus[$];
   cpl_t    exp_cpl[$];
   int      n_checks = 0;
   int      n_pass   = 0;
   int      reads_seen = 0;
   int      slave_base = 0;
   int      slave_done_after = 0;
   int      cyc = 0;

   always #5 clk = ~clk;

   dma_ctrl_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .READ_LATENCY(RL), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .length(length), .size(size), .busy(busy), .done(done), .err(err), .err_code(err_code),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
   );

   task automatic chk(input bit ok, input string name, input string detail);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   function automatic bus_ev_t mk_ev(input logic wr, input logic [2:0] addr, input logic [31:0] data);
      bus_ev_t e;
      e.wr = wr; e.addr = addr; e.data = data;
      return e;
   endfunction

   // Transfer-level model: what the DMA core should see for one request.
   task automatic model_push(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                             input logic [LEN_W-1:0] l, input logic [1:0] sz,
                             input int done_after, output logic [1:0] code);
      int   unit;
      cpl_t c;
      unit = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if (l == 0)                    code = 2'b01;
      else if (int'(l) % unit != 0)  code = 2'b10;
      else                           code = 2'b00;
      if (code != 2'b00) begin
         c.err = 1'b1; c.code = code;
         exp_cpl.push_back(c);
         return;
      end
      exp_bus.push_back(mk_ev(1'b1, 3'd0, 32'h0));
      exp_bus.push_back(mk_ev(1'b1, 3'd1, 32'(s)));
      exp_bus.push_back(mk_ev(1'b1, 3'd2, 32'(d)));
      exp_bus.push_back(mk_ev(1'b1, 3'd3, 32'(l)));
      exp_bus.push_back(mk_ev(1'b1, 3'd6, 32'h88 | 32'(unit)));
      if (done_after > 0 && done_after <= MAX_POLLS) begin
         for (int i = 0; i < done_after; i++) exp_bus.push_back(mk_ev(1'b0, 3'd0, 32'h0));
         exp_bus.push_back(mk_ev(1'b1, 3'd0, 32'h0));
         c.err = 1'b0; c.code = 2'b00;
      end else begin
         for (int i = 0; i < MAX_POLLS; i++) exp_bus.push_back(mk_ev(1'b0, 3'd0, 32'h0));
         exp_bus.push_back(mk_ev(1'b1, 3'd6, 32'h1000));
         exp_bus.push_back(mk_ev(1'b1, 3'd6, 32'h1000));
         exp_bus.push_back(mk_ev(1'b1, 3'd0, 32'h0));
         c.err = 1'b1; c.code = 2'b11;
      end
      exp_cpl.push_back(c);
   endtask

   // Status slave: the Nth read of a transfer returns DONE once N reaches slave_done_after.
   int due_q[$];
   logic [31:0] data_q[$];
   always @(negedge clk) begin
      logic [31:0] v;
      cyc++;
      if (avm_chipselect === 1'b1 && avm_write_n === 1'b1) begin
         reads_seen++;
         v = $urandom & 32'hFFFF_FFFE;
         if (slave_done_after != 0 && (reads_seen - slave_base) >= slave_done_after) v[0] = 1'b1;
         due_q.push_back(cyc + RL);
         data_q.push_back(v);
      end
      if (due_q.size() != 0 && due_q[0] == cyc) begin
         avm_readdata <= data_q.pop_front();
         void'(due_q.pop_front());
      end else begin
         avm_readdata <= $urandom;
      end
   end

   // Monitor: every strobe cycle is one transaction; every done pulse is one completion.
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      bus_ev_t ev, e;
      cpl_t    c;
      if (avm_chipselect === 1'b1) begin
         ev = mk_ev(~avm_write_n, avm_address, avm_write_n ? 32'h0 : avm_writedata);
         if (exp_bus.size() == 0) begin
            chk(1'b0, "bus_unexpected", $sformatf("got wr=%0d addr=%0d data=0x%08h, required no bus traffic",
                ev.wr, ev.addr, ev.data));
         end else begin
            e = exp_bus.pop_front();
            chk(ev === e, "bus_txn", $sformatf("got wr=%0d addr=%0d data=0x%08h, required wr=%0d addr=%0d data=0x%08h",
                ev.wr, ev.addr, ev.data, e.wr, e.addr, e.data));
         end
      end else begin
         chk(avm_write_n === 1'b1, "idle_write_n", $sformatf("got write_n=%b with chipselect low, required 1", avm_write_n));
      end
      chk(!(err === 1'b1 && done !== 1'b1), "err_alone", $sformatf("got err=%b done=%b, required err only with done", err, done));
      if (done === 1'b1) begin
         if (exp_cpl.size() == 0) begin
            chk(1'b0, "done_unexpected", "got done pulse, required none");
         end else begin
            c = exp_cpl.pop_front();
            chk(err === c.err && err_code === c.code, "completion",
                $sformatf("got err=%b err_code=%b, required err=%b err_code=%b", err, err_code, c.err, c.code));
            chk(busy === 1'b0 && busy_prev === 1'b1, "busy_fall",
                $sformatf("got busy=%b (prev %b) at done, required 0 (prev 1)", busy, busy_prev));
            chk(exp_bus.size() == 0, "bus_before_done",
                $sformatf("got %0d transactions outstanding at done, required 0", exp_bus.size()));
         end
      end
      busy_prev = busy;
   end

   task automatic run_txn(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [LEN_W-1:0] l, input logic [1:0] sz,
                          input int done_after, input bit junk);
      logic [1:0] code;
      int         wait_cyc;
      model_push(s, d, l, sz, done_after, code);
      $display("txn src=0x%05h dst=0x%05h len=%0d size=%0d done_after=%0d junk=%0d expect_code=%0d",
               s, d, l, sz, done_after, junk, code);
      slave_done_after = done_after;
      slave_base       = reads_seen;
      src_addr = s; dst_addr = d; length = l; size = sz; start = 1'b1;
      @(negedge clk);
      chk(busy === 1'b1, "busy_after_start", $sformatf("got busy=%b, required 1", busy));
      if (junk) begin
         src_addr = ADDR_W'($urandom); dst_addr = ADDR_W'($urandom);
         length = LEN_W'($urandom); size = 2'($urandom);
      end else begin
         start = 1'b0;
      end
      if (code != 2'b00) begin
         chk(done === 1'b0 && avm_chipselect === 1'b0, "reject_early",
             $sformatf("got done=%b cs=%b one cycle after start, required 0/0", done, avm_chipselect));
         @(negedge clk);
         chk(done === 1'b1 && err === 1'b1, "reject_timing",
             $sformatf("got done=%b err=%b two cycles after start, required 1/1", done, err));
      end else begin
         wait_cyc = 0;
         while (done !== 1'b1 && wait_cyc < 600) begin
            @(negedge clk);
            wait_cyc++;
         end
         chk(done === 1'b1, "done_wait", $sformatf("got no done within %0d cycles, required done", wait_cyc));
      end
      // A start in the done cycle must be ignored.
      if (junk) begin
         start = 1'b1; length = LEN_W'($urandom); size = 2'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      chk(busy === 1'b0, "busy_after_done", $sformatf("got busy=%b after done, required 0", busy));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test within time limit, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [ADDR_W-1:0] s, d;
      logic [LEN_W-1:0]  l;
      reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0; size = '0;
      repeat (3) @(negedge clk);
      chk(busy === 1'b0 && done === 1'b0 && err === 1'b0, "reset_flags",
          $sformatf("got busy=%b done=%b err=%b, required 0/0/0", busy, done, err));
      chk(err_code === 2'b00, "reset_err_code", $sformatf("got %b, required 00", err_code));
      chk(avm_chipselect === 1'b0 && avm_write_n === 1'b1, "reset_strobes",
          $sformatf("got cs=%b write_n=%b, required 0/1", avm_chipselect, avm_write_n));
      chk(avm_address === 3'd0 && avm_writedata === 32'h0, "reset_bus",
          $sformatf("got addr=%0d data=0x%08h, required 0/0", avm_address, avm_writedata));
      reset = 1'b1;
      @(negedge clk);

      run_txn(20'h00100, 20'h00200, 11'd16, 2'b10, 3, 1'b0);
      run_txn(20'h00100, 20'h00200, 11'd0,  2'b00, 3, 1'b0);
      run_txn(20'h00100, 20'h00200, 11'd6,  2'b10, 3, 1'b0);
      run_txn(20'h00100, 20'h00200, 11'd6,  2'b01, 2, 1'b0);
      run_txn(20'h00123, 20'h00456, 11'd8,  2'b11, 0, 1'b0);
      run_txn(20'hABCDE, 20'h12345, 11'd7,  2'b00, MAX_POLLS, 1'b1);

      // Reset asserted while the length write is on the bus.
      $display("txn reset during length write");
      exp_bus.push_back(mk_ev(1'b1, 3'd0, 32'h0));
      exp_bus.push_back(mk_ev(1'b1, 3'd1, 32'h00300));
      exp_bus.push_back(mk_ev(1'b1, 3'd2, 32'h00400));
      exp_bus.push_back(mk_ev(1'b1, 3'd3, 32'd32));
      slave_done_after = 1; slave_base = reads_seen;
      src_addr = 20'h00300; dst_addr = 20'h00400; length = 11'd32; size = 2'b10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk(avm_chipselect === 1'b1 && avm_address === 3'd3, "wr_len_cycle",
          $sformatf("got cs=%b addr=%0d, required 1/3", avm_chipselect, avm_address));
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk(avm_chipselect === 1'b0 && avm_write_n === 1'b1, "reset_mid_strobes",
          $sformatf("got cs=%b write_n=%b, required 0/1", avm_chipselect, avm_write_n));
      chk(busy === 1'b0 && done === 1'b0, "reset_mid_flags",
          $sformatf("got busy=%b done=%b, required 0/0", busy, done));
      @(negedge clk);
      reset = 1'b1;
      chk(exp_bus.size() == 0, "reset_mid_seen",
          $sformatf("got %0d transactions unseen, required 0", exp_bus.size()));
      repeat (6) @(negedge clk);
      run_txn(20'h00300, 20'h00400, 11'd32, 2'b10, 1, 1'b0);

      for (int i = 0; i < 24; i++) begin
         s = ADDR_W'($urandom);
         d = ADDR_W'($urandom);
         case ($urandom_range(0, 5))
            0:       l = '0;
            1:       l = LEN_W'($urandom);
            default: l = LEN_W'($urandom_range(1, 500) * 4);
         endcase
         run_txn(s, d, l, 2'($urandom_range(0, 3)), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      chk(exp_bus.size() == 0 && exp_cpl.size() == 0, "scoreboard_drained",
          $sformatf("got %0d bus and %0d completions outstanding, required 0/0", exp_bus.size(), exp_cpl.size()));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
